// File: rtl/branch_predictor_table_pkg.sv
// Shared types and default widths for the branch direction predictor and the
// pipeline registers that carry its checkpoint tag.
package branch_predictor_table_pkg;

    localparam int unsigned BP_IDX_W    = 6;
    localparam int unsigned BP_CTR_BITS = 2;
    localparam int unsigned BP_GHR_BITS = 4;
    localparam int unsigned BP_STAT_W   = 32;

    typedef struct packed {
        logic [BP_IDX_W-1:0]    index;
        logic [BP_GHR_BITS-1:0] ghr;
    } bp_tag_t;

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// Up/down saturating counter with asynchronous reset to a parameter value.
module sat_counter #(
    parameter int unsigned         CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] RST_VAL  = '0
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                i_en,
    input  logic                i_up,
    output logic [CTR_BITS-1:0] o_count
);

    logic [CTR_BITS-1:0] r_count;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_count <= RST_VAL;
        end else if (i_en) begin
            if (i_up && (r_count != '1)) begin
                r_count <= r_count + CTR_BITS'(1);
            end else if (!i_up && (r_count != '0)) begin
                r_count <= r_count - CTR_BITS'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_table.sv
// Direction predictor: table of saturating counters, bimodal or gshare indexed,
// with speculative global history, mispredict repair and saturating statistics.
module branch_predictor_table
    import branch_predictor_table_pkg::*;
#(
    parameter int unsigned IDX_W    = BP_IDX_W,
    parameter int unsigned CTR_BITS = BP_CTR_BITS,
    parameter int unsigned GHR_BITS = BP_GHR_BITS,
    parameter int unsigned GSHARE   = 0,
    parameter int unsigned STAT_W   = BP_STAT_W
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    output logic              pred_taken,
    output bp_tag_t           pred_tag,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              resolve_pred,
    input  bp_tag_t           resolve_tag,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned         ENTRIES = 2 ** IDX_W;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    logic [GHR_BITS-1:0] r_ghr;
    logic [STAT_W-1:0]   r_lookups;
    logic [STAT_W-1:0]   r_mispredicts;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_res_idx;
    logic [GHR_BITS-1:0] w_res_ghr;
    logic                w_misp;
    logic [CTR_BITS-1:0] w_ctr [ENTRIES];
    logic                w_unused_pc;

    assign w_unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

    // Lookup index: PC word bits, optionally hashed with zero-extended history.
    always_comb begin
        w_idx = lookup_pc[IDX_W+1:2];
        if (GSHARE != 0) begin
            w_idx = w_idx ^ IDX_W'(r_ghr);
        end
    end

    assign w_res_idx = IDX_W'(resolve_tag.index);
    assign w_res_ghr = GHR_BITS'(resolve_tag.ghr);
    assign w_misp    = resolve_valid && (resolve_taken != resolve_pred);

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        sat_counter #(
            .CTR_BITS (CTR_BITS),
            .RST_VAL  (CTR_RST)
        ) u_ctr (
            .Clock   (Clock),
            .nReset  (nReset),
            .i_en    (resolve_valid && (w_res_idx == IDX_W'(gi))),
            .i_up    (resolve_taken),
            .o_count (w_ctr[gi])
        );
    end

    // Read returns the pre-update counter; no bypass from a same-cycle resolve.
    always_comb begin
        pred_taken     = w_ctr[w_idx][CTR_BITS-1];
        pred_tag       = '0;
        pred_tag.index = BP_IDX_W'(w_idx);
        pred_tag.ghr   = BP_GHR_BITS'(r_ghr);
    end

    assign mispredict = w_misp;

    // Repair on mispredict wins over the wrong-path speculative shift.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_ghr <= '0;
        end else if (GSHARE != 0) begin
            if (w_misp) begin
                r_ghr <= GHR_BITS'({w_res_ghr, resolve_taken});
            end else if (lookup_valid) begin
                r_ghr <= GHR_BITS'({r_ghr, pred_taken});
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_lookups     <= '0;
            r_mispredicts <= '0;
        end else begin
            if (lookup_valid && !w_misp && (r_lookups != '1)) begin
                r_lookups <= r_lookups + STAT_W'(1);
            end
            if (w_misp && (r_mispredicts != '1)) begin
                r_mispredicts <= r_mispredicts + STAT_W'(1);
            end
        end
    end

    assign stat_lookups     = r_lookups;
    assign stat_mispredicts = r_mispredicts;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench: a gshare instance (4-bit stats) and a bimodal instance
// (8-bit stats) share stimulus and are checked against an array-based model.
module tb_branch_predictor_table;
    import branch_predictor_table_pkg::*;

    localparam int MAX0 = 15;
    localparam int MAX1 = 255;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        lookup_valid, resolve_valid, resolve_taken, resolve_pred;
    logic [31:0] lookup_pc;
    bp_tag_t     resolve_tag;

    logic        pred_g, pred_b, misp_g, misp_b;
    bp_tag_t     tag_g, tag_b;
    logic [3:0]  sl_g, sm_g;
    logic [7:0]  sl_b, sm_b;

    always #5 Clock = ~Clock;

    branch_predictor_table #(.IDX_W(6), .CTR_BITS(2), .GHR_BITS(4), .GSHARE(1), .STAT_W(4)) u_dut_g (
        .Clock(Clock), .nReset(nReset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_taken(pred_g), .pred_tag(tag_g), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .resolve_pred(resolve_pred), .resolve_tag(resolve_tag),
        .mispredict(misp_g), .stat_lookups(sl_g), .stat_mispredicts(sm_g));

    branch_predictor_table #(.IDX_W(6), .CTR_BITS(2), .GHR_BITS(4), .GSHARE(0), .STAT_W(8)) u_dut_b (
        .Clock(Clock), .nReset(nReset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_taken(pred_b), .pred_tag(tag_b), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .resolve_pred(resolve_pred), .resolve_tag(resolve_tag),
        .mispredict(misp_b), .stat_lookups(sl_b), .stat_mispredicts(sm_b));

    typedef struct {
        bit lv;
        bit misp;
        bit pred0, pred1;
        int idx0, idx1, ghr0;
        int sl0, sl1, sm0, sm1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: index 0 = gshare instance, 1 = bimodal instance.
    int m_tbl [2][64];
    int m_ghr;
    int m_sl [2];
    int m_sm [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) m_tbl[k][i] = 1;
            m_sl[k] = 0;
            m_sm[k] = 0;
        end
        m_ghr = 0;
    endtask

    task automatic drive(input bit lv, input logic [31:0] pc, input bit rv, input bit rt,
                         input bit rp, input int ri, input int rg);
        exp_t e;
        int   ix [2];
        bit   pr [2];
        bit   misp;
        @(negedge Clock);
        lookup_valid      = lv;
        lookup_pc         = pc;
        resolve_valid     = rv;
        resolve_taken     = rt;
        resolve_pred      = rp;
        resolve_tag.index = 6'(ri);
        resolve_tag.ghr   = 4'(rg);
        misp  = rv && (rt != rp);
        ix[1] = int'(pc[7:2]);
        ix[0] = ix[1] ^ m_ghr;
        for (int k = 0; k < 2; k++) pr[k] = (m_tbl[k][ix[k]] >= 2);
        e.lv = lv;  e.misp = misp;
        e.pred0 = pr[0]; e.pred1 = pr[1];
        e.idx0 = ix[0];  e.idx1 = ix[1];  e.ghr0 = m_ghr;
        e.sl0 = m_sl[0]; e.sl1 = m_sl[1]; e.sm0 = m_sm[0]; e.sm1 = m_sm[1];
        q.push_back(e);
        // State seen after the coming rising edge.
        for (int k = 0; k < 2; k++) begin
            if (rv) begin
                if (rt) m_tbl[k][ri] = (m_tbl[k][ri] < 3) ? m_tbl[k][ri] + 1 : 3;
                else    m_tbl[k][ri] = (m_tbl[k][ri] > 0) ? m_tbl[k][ri] - 1 : 0;
            end
            if (lv && !misp && m_sl[k] < ((k == 0) ? MAX0 : MAX1)) m_sl[k]++;
            if (misp && m_sm[k] < ((k == 0) ? MAX0 : MAX1)) m_sm[k]++;
        end
        if (misp)    m_ghr = (rg * 2 + int'(rt)) % 16;
        else if (lv) m_ghr = (m_ghr * 2 + int'(pr[0])) % 16;
    endtask

    // Asynchronous reset asserted between clock edges; effects checked at once.
    task automatic do_reset();
        @(negedge Clock);
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
        #3;
        nReset = 1'b0;
        model_reset();
        #1;
        chk("rst_stat_lookups_g", int'(sl_g), 0);
        chk("rst_stat_mispredicts_g", int'(sm_g), 0);
        chk("rst_stat_lookups_b", int'(sl_b), 0);
        chk("rst_stat_mispredicts_b", int'(sm_b), 0);
        lookup_valid = 1'b1;
        lookup_pc    = $urandom;
        #1;
        chk("rst_pred_g", int'(pred_g), 0);
        chk("rst_pred_b", int'(pred_b), 0);
        chk("rst_ghr_g", int'(tag_g.ghr), 0);
        lookup_valid = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    // Monitor: pops one expectation per driven cycle and compares settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mispredict_g", int'(misp_g), int'(e.misp));
                chk("mispredict_b", int'(misp_b), int'(e.misp));
                if (e.lv) begin
                    chk("pred_taken_g", int'(pred_g), int'(e.pred0));
                    chk("tag_index_g", int'(tag_g.index), e.idx0);
                    chk("tag_ghr_g", int'(tag_g.ghr), e.ghr0);
                    chk("pred_taken_b", int'(pred_b), int'(e.pred1));
                    chk("tag_index_b", int'(tag_b.index), e.idx1);
                    chk("tag_ghr_b", int'(tag_b.ghr), 0);
                end
                chk("stat_lookups_g", int'(sl_g), e.sl0);
                chk("stat_mispredicts_g", int'(sm_g), e.sm0);
                chk("stat_lookups_b", int'(sl_b), e.sl1);
                chk("stat_mispredicts_b", int'(sm_b), e.sm1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        bit          rt;
        nReset        = 1'b0;
        lookup_valid  = 1'b0;
        lookup_pc     = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_pred  = 1'b0;
        resolve_tag   = '0;
        model_reset();
        do_reset();

        // Reset lookup, then idx 0 trained up to saturation and back one step.
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        drive(0, 32'h0,   1, 1, 1, 0, 0);
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        drive(0, 32'h0,   1, 1, 1, 0, 0);
        drive(0, 32'h0,   1, 1, 1, 0, 0);
        drive(0, 32'h0,   1, 0, 0, 0, 0);
        drive(1, 32'h100, 0, 0, 0, 0, 0);

        // idx 5 trained down to 0, then one taken.
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 1, 0, 0, 5, 0);
        drive(1, 32'h114, 0, 0, 0, 0, 0);
        drive(0, 32'h0,   1, 1, 1, 5, 0);
        drive(1, 32'h114, 0, 0, 0, 0, 0);

        // Same-cycle lookup and update of idx 3.
        do_reset();
        drive(1, 32'h10C, 1, 1, 1, 3, 0);
        drive(1, 32'h10C, 0, 0, 0, 0, 0);

        // History: predicted-not-taken lookups, then repair with a wrong-path lookup.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 32'h208, 0, 0, 0, 0, 0);
        drive(1, 32'h208, 1, 1, 0, 9, 5);
        drive(1, 32'h208, 0, 0, 0, 0, 0);

        // Mispredict counter saturation.
        for (int i = 0; i < 20; i++) drive(0, 32'h0, 1, 1, 0, 7, 3);
        drive(1, 32'h104, 0, 0, 0, 0, 0);

        // Randomized traffic over a small index set, with a reset mid-stream.
        for (int n = 0; n < 700; n++) begin
            if (n == 350) do_reset();
            pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            rt = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) != 0, rt,
                  ($urandom_range(0, 3) == 0) ? !rt : rt,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        @(negedge Clock);
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
        @(negedge Clock);
        #3;
        chk("queue_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
